// File: rtl/dma_channel_arbiter.sv
//==============================================================================
// dma_channel_arbiter : DREQ/DACK channel arbiter with fixed or rotating priority
// Revision 1.0
//==============================================================================
`default_nettype none

module dma_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PW     = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              dreqActiveLow,
  input  logic              dackActiveLow,
  input  logic [NUM_CH-1:0] mask,
  input  logic              ctrlDisable,
  input  logic              rotatePriority,
  input  logic              hlda,
  input  logic              xferDone,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic [NUM_CH-1:0] chSel,
  output logic              validDack,
  output logic [PW-1:0]     prioPtr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state, w_stateNxt;
  logic              r_hrq, w_hrqNxt;
  logic              r_valid, w_validNxt;
  logic [NUM_CH-1:0] r_chSel, w_chSelNxt;
  logic [PW-1:0]     r_ptr, w_ptrNxt;
  logic [PW-1:0]     r_grantIdx, w_grantIdxNxt;

  logic [NUM_CH-1:0] w_vreq;
  logic [NUM_CH-1:0] w_winOH;
  logic [PW-1:0]     w_winIdx;
  logic [PW:0]       w_cand;

  assign w_vreq = (dreq ^ {NUM_CH{dreqActiveLow}}) & ~mask;

  // Scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    w_winIdx = '0;
    w_winOH  = '0;
    w_cand   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (PW + 1)'(k);
      if (w_cand >= (PW + 1)'(NUM_CH)) begin
        w_cand = w_cand - (PW + 1)'(NUM_CH);
      end
      if (w_vreq[w_cand[PW-1:0]]) begin
        w_winIdx = w_cand[PW-1:0];
        w_winOH  = '0;
        w_winOH[w_cand[PW-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNxt    = r_state;
    w_hrqNxt      = r_hrq;
    w_validNxt    = r_valid;
    w_chSelNxt    = r_chSel;
    w_ptrNxt      = r_ptr;
    w_grantIdxNxt = r_grantIdx;
    case (r_state)
      S_IDLE: begin
        if ((|w_vreq) && !ctrlDisable) begin
          w_stateNxt = S_REQ;
          w_hrqNxt   = 1'b1;
        end
      end
      S_REQ: begin
        // A vanished request beats a simultaneous hold acknowledge.
        if (w_vreq == '0) begin
          w_stateNxt = S_IDLE;
          w_hrqNxt   = 1'b0;
        end else if (hlda) begin
          w_stateNxt    = S_GRANT;
          w_chSelNxt    = w_winOH;
          w_validNxt    = 1'b1;
          w_grantIdxNxt = w_winIdx;
        end
      end
      S_GRANT: begin
        if (!hlda) begin
          w_stateNxt = S_IDLE;
          w_hrqNxt   = 1'b0;
          w_chSelNxt = '0;
          w_validNxt = 1'b0;
        end else if (xferDone) begin
          w_stateNxt = S_RELEASE;
          w_hrqNxt   = 1'b0;
          w_chSelNxt = '0;
          w_validNxt = 1'b0;
          if (rotatePriority) begin
            w_ptrNxt = (r_grantIdx == PW'(NUM_CH - 1)) ? '0 : r_grantIdx + 1'b1;
          end
        end
      end
      S_RELEASE: begin
        w_stateNxt = S_IDLE;
      end
      default: begin
        w_stateNxt = S_IDLE;
        w_hrqNxt   = 1'b0;
        w_chSelNxt = '0;
        w_validNxt = 1'b0;
      end
    endcase
    if (!rotatePriority) begin
      w_ptrNxt = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_hrq      <= 1'b0;
      r_valid    <= 1'b0;
      r_chSel    <= '0;
      r_ptr      <= '0;
      r_grantIdx <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_hrq      <= w_hrqNxt;
      r_valid    <= w_validNxt;
      r_chSel    <= w_chSelNxt;
      r_ptr      <= w_ptrNxt;
      r_grantIdx <= w_grantIdxNxt;
    end
  end

  assign hrq       = r_hrq;
  assign chSel     = r_chSel;
  assign validDack = r_valid;
  assign prioPtr   = r_ptr;
  assign dack      = r_chSel ^ {NUM_CH{dackActiveLow}};

endmodule

`default_nettype wire

// File: tb/tb_dma_channel_arbiter.sv
//==============================================================================
// tb_dma_channel_arbiter : directed bench for 4- and 5-channel arbiter instances
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       rst4, dreqAL, dackAL, dis, rot, hlda, xfer;
  logic [3:0] dreq, mask;
  logic       hrq, vd;
  logic [3:0] dack, chSel;
  logic [1:0] ptr;

  logic       rst5, rot5, hlda5, xfer5;
  logic [4:0] dreq5;
  logic       hrq5, vd5;
  logic [4:0] dack5, chSel5;
  logic [2:0] ptr5;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.NUM_CH(4)) u_dut (
    .CLK(CLK), .RESET(rst4), .dreq(dreq), .dreqActiveLow(dreqAL),
    .dackActiveLow(dackAL), .mask(mask), .ctrlDisable(dis),
    .rotatePriority(rot), .hlda(hlda), .xferDone(xfer),
    .hrq(hrq), .dack(dack), .chSel(chSel), .validDack(vd), .prioPtr(ptr)
  );

  dma_channel_arbiter #(.NUM_CH(5)) u_dut5 (
    .CLK(CLK), .RESET(rst5), .dreq(dreq5), .dreqActiveLow(1'b0),
    .dackActiveLow(1'b0), .mask(5'b00000), .ctrlDisable(1'b0),
    .rotatePriority(rot5), .hlda(hlda5), .xferDone(xfer5),
    .hrq(hrq5), .dack(dack5), .chSel(chSel5), .validDack(vd5), .prioPtr(ptr5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; dreqAL = 1'b0; dackAL = 1'b0; dis = 1'b0; rot = 1'b0;
    hlda = 1'b0; xfer = 1'b0; dreq = 4'h0; mask = 4'h0;
    rst5 = 1'b1; rot5 = 1'b0; hlda5 = 1'b0; xfer5 = 1'b0; dreq5 = 5'h00;
    tick(); tick();
    chk("rst_hrq", 32'(hrq), 'h0);
    chk("rst_chSel", 32'(chSel), 'h0);
    chk("rst_valid", 32'(vd), 'h0);
    chk("rst_ptr", 32'(ptr), 'h0);
    chk("rst_dack_hi", 32'(dack), 'h0);
    dackAL = 1'b1; #1;
    chk("rst_dack_lo", 32'(dack), 'hf);
    dackAL = 1'b0;
    rst4 = 1'b0; rst5 = 1'b0;
    tick();

    // Fixed priority, hold acknowledge two cycles after hrq
    dreq = 4'b1010;
    tick();
    chk("fix_hrq_lat", 32'(hrq), 'h1);
    chk("fix_chSel_req", 32'(chSel), 'h0);
    tick();
    hlda = 1'b1;
    tick();
    chk("fix_chSel", 32'(chSel), 'h2);
    chk("fix_dack", 32'(dack), 'h2);
    chk("fix_valid", 32'(vd), 'h1);
    chk("fix_ptr", 32'(ptr), 'h0);
    xfer = 1'b1;
    tick();
    chk("fix_rel_hrq", 32'(hrq), 'h0);
    chk("fix_rel_chSel", 32'(chSel), 'h0);
    chk("fix_rel_valid", 32'(vd), 'h0);
    chk("fix_rel_ptr", 32'(ptr), 'h0);
    xfer = 1'b0; dreq = 4'h0;
    tick();

    // Rotating: ch1, then ch3, then ch0
    rot = 1'b1; dreq = 4'b0010;
    tick(); tick();
    chk("rot_g1", 32'(chSel), 'h2);
    dreq = 4'b1011; xfer = 1'b1;
    tick();
    chk("rot_ptr2", 32'(ptr), 'h2);
    xfer = 1'b0;
    tick();
    chk("rot_gap_hrq", 32'(hrq), 'h0);
    tick(); tick();
    chk("rot_g2", 32'(chSel), 'h8);
    xfer = 1'b1;
    tick();
    chk("rot_ptr0", 32'(ptr), 'h0);
    xfer = 1'b0;
    tick(); tick(); tick();
    chk("rot_g3", 32'(chSel), 'h1);
    xfer = 1'b1;
    tick();
    chk("rot_ptr1", 32'(ptr), 'h1);
    xfer = 1'b0; dreq = 4'h0;
    tick();
    rot = 1'b0;
    tick();
    chk("fix_ptr_clr", 32'(ptr), 'h0);

    // Active-low pins, mask and disable during GRANT are ignored
    dreqAL = 1'b1; dackAL = 1'b1; dreq = 4'b1110;
    #1;
    chk("al_idle_dack", 32'(dack), 'hf);
    tick(); tick();
    chk("al_chSel", 32'(chSel), 'h1);
    chk("al_dack", 32'(dack), 'he);
    mask = 4'b0001; dreq = 4'b1111; dis = 1'b1;
    tick();
    chk("al_hold_chSel", 32'(chSel), 'h1);
    chk("al_hold_hrq", 32'(hrq), 'h1);
    xfer = 1'b1;
    tick();
    chk("al_done_chSel", 32'(chSel), 'h0);
    chk("al_done_dack", 32'(dack), 'hf);
    xfer = 1'b0; mask = 4'h0; dis = 1'b0; dreqAL = 1'b0; dackAL = 1'b0; dreq = 4'h0;
    tick();

    // Bus lost together with xferDone, rotating
    rot = 1'b1; dreq = 4'b0100;
    tick(); tick();
    chk("lost_g", 32'(chSel), 'h4);
    hlda = 1'b0; xfer = 1'b1;
    tick();
    chk("lost_hrq", 32'(hrq), 'h0);
    chk("lost_chSel", 32'(chSel), 'h0);
    chk("lost_dack", 32'(dack), 'h0);
    chk("lost_valid", 32'(vd), 'h0);
    chk("lost_ptr", 32'(ptr), 'h0);
    xfer = 1'b0;
    tick();
    chk("lost_idle_req", 32'(hrq), 'h1);
    dreq = 4'h0; hlda = 1'b1;
    tick();
    chk("drop_hrq", 32'(hrq), 'h0);
    chk("drop_chSel", 32'(chSel), 'h0);
    dis = 1'b1; dreq = 4'b0001;
    tick();
    chk("dis_hrq", 32'(hrq), 'h0);
    dis = 1'b0; dreq = 4'h0;
    tick();

    // Five channels: wrap from ch4, then async reset mid-GRANT
    rot5 = 1'b1; hlda5 = 1'b1; dreq5 = 5'b00100;
    tick(); tick();
    chk("c5_g2", 32'(chSel5), 'h04);
    xfer5 = 1'b1;
    tick();
    chk("c5_ptr3", 32'(ptr5), 'h3);
    xfer5 = 1'b0; dreq5 = 5'b10000;
    tick(); tick(); tick();
    chk("c5_g4", 32'(chSel5), 'h10);
    xfer5 = 1'b1;
    tick();
    chk("c5_wrap", 32'(ptr5), 'h0);
    xfer5 = 1'b0; dreq5 = 5'b00010;
    tick(); tick(); tick();
    chk("c5_g1", 32'(chSel5), 'h02);
    rst5 = 1'b1;
    #1;
    chk("c5_rst_hrq", 32'(hrq5), 'h0);
    chk("c5_rst_chSel", 32'(chSel5), 'h00);
    chk("c5_rst_valid", 32'(vd5), 'h0);
    chk("c5_rst_dack", 32'(dack5), 'h00);
    rst5 = 1'b0;
    tick();
    chk("c5_after_rst", 32'(hrq5), 'h1);
    chk("c5_after_rst_sel", 32'(chSel5), 'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
